// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg: constants and types shared by the ROM download sequencer.
//   SLOT_*      - SDRAM ROM slot numbers (upper 9 address bits of mem_a)
//   PAGE_BYTES  - size of one download page
//   LAST_OFFSET - in-page offset of the final byte of a page
//   state_e     - per-byte write sequencer states
package rom_loader_pkg;

    localparam logic [8:0] SLOT_OS     = 9'h000;
    localparam logic [8:0] SLOT_BASIC  = 9'h100;
    localparam logic [8:0] SLOT_AMSDOS = 9'h107;

    localparam int PAGE_BYTES = 16384;
    localparam int OFFSET_W   = $clog2(PAGE_BYTES);

    localparam logic [OFFSET_W-1:0] LAST_OFFSET = OFFSET_W'(PAGE_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        STROBE = 2'd2
    } state_e;

endpackage

// File: rtl/rom_page_map.sv
// rom_page_map: translates a 16 KB download page number to its SDRAM ROM
// slot and bank.
//   page  in  11  download page (ioctl_addr[24:14])
//   slot  out  9  SDRAM ROM slot
//   bank  out  2  SDRAM bank
//   valid out  1  page is one of the mapped pages
module rom_page_map
    import rom_loader_pkg::*;
(
    input  logic [10:0] page,
    output logic [8:0]  slot,
    output logic [1:0]  bank,
    output logic        valid
);

    always_comb begin
        slot  = SLOT_OS;
        bank  = 2'd0;
        valid = 1'b0;
        case (page)
            11'd0: begin slot = SLOT_OS;     bank = 2'd0; valid = 1'b1; end
            11'd1: begin slot = SLOT_BASIC;  bank = 2'd0; valid = 1'b1; end
            11'd2: begin slot = SLOT_AMSDOS; bank = 2'd0; valid = 1'b1; end
            11'd3: begin slot = SLOT_OS;     bank = 2'd1; valid = 1'b1; end
            11'd4: begin slot = SLOT_BASIC;  bank = 2'd1; valid = 1'b1; end
            11'd5: begin slot = SLOT_AMSDOS; bank = 2'd1; valid = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: rtl/rom_loader.sv
// rom_loader: moves ROM image bytes from the HPS ioctl stream into SDRAM while
// the machine is held in reset. Each accepted byte is held on mem_a/mem_bank/
// mem_din and written with a strobe exactly one ce_ref period long; the HPS is
// stalled with ioctl_wait for the whole transfer.
//   clk_sys, reset        system clock, synchronous active-high reset
//   ce_ref                SDRAM slot enable (one pulse per 16 cycles)
//   download_en           ROM download in progress
//   ioctl_wr/addr/dout    HPS byte stream
//   ioctl_wait            stall request to the HPS
//   mem_we/a/bank/din     SDRAM write port (reset-side mux)
//   loaded[PAGES]         bit p set once the last byte of page p is written
//   done                  high from download end until the next download start
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int PAGES = 6
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             ce_ref,
    input  logic             download_en,
    input  logic             ioctl_wr,
    input  logic [24:0]      ioctl_addr,
    input  logic [7:0]       ioctl_dout,
    output logic             ioctl_wait,
    output logic             mem_we,
    output logic [22:0]      mem_a,
    output logic [1:0]       mem_bank,
    output logic [7:0]       mem_din,
    output logic [PAGES-1:0] loaded,
    output logic             done
);

    state_e           state_q, state_d;
    logic             mem_we_q, mem_we_d;
    logic             ioctl_wait_q, ioctl_wait_d;
    logic [22:0]      mem_a_q, mem_a_d;
    logic [1:0]       mem_bank_q, mem_bank_d;
    logic [7:0]       mem_din_q, mem_din_d;
    logic [2:0]       page_q, page_d;
    logic             last_q, last_d;
    logic [PAGES-1:0] loaded_q, loaded_d;
    logic             done_q, done_d;
    logic             dl_en_q, dl_en_d;

    logic [8:0] map_slot;
    logic [1:0] map_bank;
    logic       map_valid;
    logic       accept;

    rom_page_map u_page_map (
        .page  (ioctl_addr[24:14]),
        .slot  (map_slot),
        .bank  (map_bank),
        .valid (map_valid)
    );

    // Bytes for unmapped pages are dropped without stalling the HPS.
    assign accept = (state_q == IDLE) && download_en && ioctl_wr && map_valid && !ioctl_wait_q;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        mem_we_d   = mem_we_q;
        mem_a_d    = mem_a_q;
        mem_bank_d = mem_bank_q;
        mem_din_d  = mem_din_q;
        page_d     = page_q;
        last_d     = last_q;
        loaded_d   = loaded_q;
        done_d     = done_q;
        dl_en_d    = download_en;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    mem_a_d    = {map_slot, ioctl_addr[OFFSET_W-1:0]};
                    mem_bank_d = map_bank;
                    mem_din_d  = ioctl_dout;
                    page_d     = ioctl_addr[16:14];
                    last_d     = (ioctl_addr[OFFSET_W-1:0] == LAST_OFFSET);
                    state_d    = ARM;
                end
            end
            // ce_ref in the accept cycle is ignored: ARM only reacts to a later
            // pulse, so the strobe always covers one whole slot period.
            ARM: begin
                if (ce_ref) begin
                    mem_we_d = 1'b1;
                    state_d  = STROBE;
                end
            end
            STROBE: begin
                if (ce_ref) begin
                    mem_we_d = 1'b0;
                    state_d  = IDLE;
                    for (int p = 0; p < PAGES; p++) begin
                        if (last_q && (page_q == 3'(p))) begin
                            loaded_d[p] = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // The stall covers the transfer plus the cycle after the strobe drops,
        // so the HPS never sees wait low while the write is still completing.
        ioctl_wait_d = (state_d != IDLE) || mem_we_q;

        // Download edges; a start overrides any page completing this cycle.
        if (download_en && !dl_en_q) begin
            loaded_d = '0;
            done_d   = 1'b0;
        end else if (!download_en && dl_en_q) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values
        // regardless of statement order.
        if (reset) begin
            state_q      <= IDLE;
            mem_we_q     <= 1'b0;
            ioctl_wait_q <= 1'b0;
            mem_a_q      <= '0;
            mem_bank_q   <= '0;
            mem_din_q    <= '0;
            page_q       <= '0;
            last_q       <= 1'b0;
            loaded_q     <= '0;
            done_q       <= 1'b0;
            dl_en_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_we_q     <= mem_we_d;
            ioctl_wait_q <= ioctl_wait_d;
            mem_a_q      <= mem_a_d;
            mem_bank_q   <= mem_bank_d;
            mem_din_q    <= mem_din_d;
            page_q       <= page_d;
            last_q       <= last_d;
            loaded_q     <= loaded_d;
            done_q       <= done_d;
            dl_en_q      <= dl_en_d;
        end
    end

    assign ioctl_wait = ioctl_wait_q;
    assign mem_we     = mem_we_q;
    assign mem_a      = mem_a_q;
    assign mem_bank   = mem_bank_q;
    assign mem_din    = mem_din_q;
    assign loaded     = loaded_q;
    assign done       = done_q;

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: self-checking bench for rom_loader. A cycle counter drives
// ce_ref with a random phase; each byte's expected strobe window, stall window,
// SDRAM address/bank and page-completion state are computed from the mapping
// rules with plain arithmetic and compared against the DUT outputs.
module tb_rom_loader;

    localparam int PAGES = 6;

    logic             clk_sys = 1'b0;
    logic             reset;
    logic             ce_ref;
    logic             download_en;
    logic             ioctl_wr;
    logic [24:0]      ioctl_addr;
    logic [7:0]       ioctl_dout;
    logic             ioctl_wait;
    logic             mem_we;
    logic [22:0]      mem_a;
    logic [1:0]       mem_bank;
    logic [7:0]       mem_din;
    logic [PAGES-1:0] loaded;
    logic             done;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int ce_phase = 0;
    logic [PAGES-1:0] exp_loaded = '0;

    always #5 clk_sys = ~clk_sys;

    rom_loader #(.PAGES(PAGES)) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .ce_ref      (ce_ref),
        .download_en (download_en),
        .ioctl_wr    (ioctl_wr),
        .ioctl_addr  (ioctl_addr),
        .ioctl_dout  (ioctl_dout),
        .ioctl_wait  (ioctl_wait),
        .mem_we      (mem_we),
        .mem_a       (mem_a),
        .mem_bank    (mem_bank),
        .mem_din     (mem_din),
        .loaded      (loaded),
        .done        (done)
    );

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // After tick(), outputs reflect edge number cyc and ce_ref is set up for edge cyc+1.
    task automatic tick();
        @(posedge clk_sys);
        #1;
        cyc = cyc + 1;
        ce_ref = (((cyc + 1) % 16) == ce_phase);
    endtask

    // Reference mapping: pages 0..5, slot chosen by page mod 3, bank by page div 3.
    function automatic logic [22:0] model_addr(input logic [24:0] a);
        int page;
        int slot;
        page = int'(a[24:14]);
        case (page % 3)
            0:       slot = 0;
            1:       slot = 256;
            default: slot = 263;
        endcase
        return 23'(slot * 16384 + int'(a[13:0]));
    endfunction

    function automatic logic [1:0] model_bank(input logic [24:0] a);
        return 2'(int'(a[24:14]) / 3);
    endfunction

    task automatic send_byte(input logic [24:0] addr, input logic [7:0] data, input string tag,
                             output int a_edge, output int we_first, output int we_last,
                             output int we_cnt, output int wait_cnt);
        int page, ce1, ce2, wait_first, wait_last, bad;
        bit mapped;
        logic [22:0] exp_a;
        logic [1:0]  exp_bank;
        logic [22:0] bad_a;
        page     = int'(addr[24:14]);
        mapped   = (page < 6);
        exp_a    = model_addr(addr);
        exp_bank = model_bank(addr);
        if (mapped && addr[13:0] == 14'h3FFF) exp_loaded[page] = 1'b1;
        we_first = -1; we_last = -1; wait_first = -1; wait_last = -1;
        we_cnt = 0; wait_cnt = 0; bad = 0; bad_a = '0;

        ioctl_addr = addr;
        ioctl_dout = data;
        ioctl_wr   = 1'b1;
        a_edge     = cyc + 1;
        tick();
        ioctl_wr   = 1'b0;
        ioctl_addr = 25'($urandom);
        ioctl_dout = 8'($urandom);

        ce1 = a_edge + 1;
        while ((ce1 % 16) != ce_phase) ce1++;
        ce2 = ce1 + 16;

        for (int i = 0; i < 80; i++) begin
            if (mem_we) begin
                if (we_first < 0) we_first = cyc;
                we_last = cyc;
                we_cnt++;
            end
            if (ioctl_wait) begin
                if (wait_first < 0) wait_first = cyc;
                wait_last = cyc;
                wait_cnt++;
                if (mem_a !== exp_a || mem_bank !== exp_bank || mem_din !== data) begin
                    bad++;
                    bad_a = mem_a;
                end
            end
            if (mapped ? (wait_cnt > 0 && !ioctl_wait) : (i >= 40)) break;
            tick();
        end

        if (mapped) begin
            n_tests++;
            if (wait_first != a_edge) begin
                n_fail++; $display("FAIL %s wait_start: got cycle %0d expected %0d", tag, wait_first, a_edge);
            end
            n_tests++;
            if (wait_cnt != ce2 - a_edge + 1 || wait_last != ce2) begin
                n_fail++; $display("FAIL %s wait_len: got %0d cycles ending %0d expected %0d ending %0d",
                                   tag, wait_cnt, wait_last, ce2 - a_edge + 1, ce2);
            end
            n_tests++;
            if (we_first != ce1) begin
                n_fail++; $display("FAIL %s we_start: got cycle %0d expected %0d", tag, we_first, ce1);
            end
            n_tests++;
            if (we_cnt != 16 || we_last != ce2 - 1) begin
                n_fail++; $display("FAIL %s we_len: got %0d cycles ending %0d expected 16 ending %0d",
                                   tag, we_cnt, we_last, ce2 - 1);
            end
            n_tests++;
            if (bad != 0) begin
                n_fail++; $display("FAIL %s hold: %0d bad cycles, mem_a got %h expected %h", tag, bad, bad_a, exp_a);
            end
        end else begin
            n_tests++;
            if (we_cnt != 0) begin
                n_fail++; $display("FAIL %s unmapped_we: got %0d strobe cycles expected 0", tag, we_cnt);
            end
            n_tests++;
            if (wait_cnt != 0) begin
                n_fail++; $display("FAIL %s unmapped_wait: got %0d wait cycles expected 0", tag, wait_cnt);
            end
        end
        n_tests++;
        if (loaded !== exp_loaded) begin
            n_fail++; $display("FAIL %s loaded: got %b expected %b", tag, loaded, exp_loaded);
        end
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        download_en = 1'b0;
        ioctl_wr    = 1'b0;
        ioctl_addr  = '0;
        ioctl_dout  = '0;
        ce_phase    = int'($urandom_range(0, 15));
        ce_ref      = (((cyc + 1) % 16) == ce_phase);
        repeat (3) tick();
        n_tests++;
        if ({ioctl_wait, mem_we, done} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ctrl: got wait/we/done %b expected 000", {ioctl_wait, mem_we, done});
        end
        n_tests++;
        if (mem_a !== 23'd0 || mem_bank !== 2'd0 || mem_din !== 8'd0) begin
            n_fail++; $display("FAIL reset_bus: got a=%h bank=%h din=%h expected zeros", mem_a, mem_bank, mem_din);
        end
        n_tests++;
        if (loaded !== '0) begin
            n_fail++; $display("FAIL reset_loaded: got %b expected 0", loaded);
        end
        reset       = 1'b0;
        download_en = 1'b1;
        exp_loaded  = '0;
        repeat (2) tick();
    endtask

    task automatic test_mapped_byte();
        int a, wf, wl, wc, tc;
        send_byte(25'h04123, 8'h5A, "mapped", a, wf, wl, wc, tc);
        n_tests++;
        if (mem_a !== 23'h400123 || mem_bank !== 2'd0 || mem_din !== 8'h5A) begin
            n_fail++; $display("FAIL mapped_bus: got a=%h bank=%h din=%h expected 400123/0/5a", mem_a, mem_bank, mem_din);
        end
        n_tests++;
        if (wc != 16) begin
            n_fail++; $display("FAIL mapped_we16: got %0d expected 16", wc);
        end
        n_tests++;
        if (a + tc - 1 - wl != 1) begin
            n_fail++; $display("FAIL mapped_wait_tail: wait fell %0d cycles after we expected 1", a + tc - 1 - wl);
        end
    endtask

    task automatic test_bank1();
        int a, wf, wl, wc, tc;
        send_byte(25'h17FFF, 8'($urandom), "bank1", a, wf, wl, wc, tc);
        n_tests++;
        if (mem_a !== 23'h41FFFF || mem_bank !== 2'd1) begin
            n_fail++; $display("FAIL bank1_bus: got a=%h bank=%h expected 41ffff/1", mem_a, mem_bank);
        end
        n_tests++;
        if (loaded !== 6'b100000) begin
            n_fail++; $display("FAIL bank1_loaded: got %b expected 100000", loaded);
        end
    endtask

    task automatic test_unmapped();
        int a, wf, wl, wc, tc;
        send_byte(25'h18000, 8'($urandom), "unmapped", a, wf, wl, wc, tc);
    endtask

    task automatic test_coincident();
        int a, wf, wl, wc, tc;
        for (int i = 0; i < 16 && !ce_ref; i++) tick();
        send_byte(25'h0C000 | 25'($urandom_range(0, 16383)), 8'($urandom), "coincident", a, wf, wl, wc, tc);
        n_tests++;
        if (wf - a != 16) begin
            n_fail++; $display("FAIL coincident_rise: we rose %0d edges after accept expected 16", wf - a);
        end
        n_tests++;
        if (tc != 33) begin
            n_fail++; $display("FAIL coincident_wait: got %0d cycles expected 33", tc);
        end
    endtask

    task automatic test_reset_mid_strobe();
        int a, wf, wl, wc, tc;
        bit seen;
        seen = 1'b0;
        ioctl_addr = 25'h0BFFF;
        ioctl_dout = 8'($urandom);
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (mem_we) begin seen = 1'b1; break; end
            tick();
        end
        n_tests++;
        if (!seen) begin
            n_fail++; $display("FAIL midreset_strobe: got no strobe within 40 cycles expected one");
        end
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_loaded = '0;
        n_tests++;
        if ({mem_we, ioctl_wait} !== 2'b00 || loaded !== '0) begin
            n_fail++; $display("FAIL midreset_out: got we/wait %b loaded %b expected 00/0", {mem_we, ioctl_wait}, loaded);
        end
        repeat (2) tick();
        send_byte(25'h0BFFF, 8'($urandom), "after_reset", a, wf, wl, wc, tc);
    endtask

    task automatic test_random_bytes();
        int a, wf, wl, wc, tc;
        logic [24:0] addr;
        for (int n = 0; n < 16; n++) begin
            addr = {8'd0, 3'($urandom_range(0, 7)), 14'($urandom)};
            if ($urandom_range(0, 3) == 0) addr[13:0] = 14'h3FFF;
            send_byte(addr, 8'($urandom), "random", a, wf, wl, wc, tc);
            repeat ($urandom_range(0, 5)) tick();
        end
    endtask

    task automatic test_stream();
        int a, wf, wl, wc, tc;
        // Close the current download, then start a fresh one.
        download_en = 1'b0;
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++; $display("FAIL done_during: got %b expected 0", done);
        end
        tick();
        n_tests++;
        if (done !== 1'b1 || loaded !== exp_loaded) begin
            n_fail++; $display("FAIL done_rise1: got done %b loaded %b expected 1/%b", done, loaded, exp_loaded);
        end
        tick();
        download_en = 1'b1;
        tick();
        exp_loaded = '0;
        n_tests++;
        if (done !== 1'b0 || loaded !== '0) begin
            n_fail++; $display("FAIL start_clear1: got done %b loaded %b expected 0/0", done, loaded);
        end
        for (int p = 0; p < 6; p++) begin
            for (int k = 0; k < 2; k++)
                send_byte({8'd0, 3'(p), 14'($urandom_range(0, 16382))}, 8'($urandom), "stream", a, wf, wl, wc, tc);
            send_byte({8'd0, 3'(p), 14'h3FFF}, 8'($urandom), "stream_last", a, wf, wl, wc, tc);
        end
        n_tests++;
        if (loaded !== 6'b111111) begin
            n_fail++; $display("FAIL stream_all: got %b expected 111111", loaded);
        end
        download_en = 1'b0;
        tick();
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++; $display("FAIL done_rise2: got %b expected 1", done);
        end
        repeat (3) tick();
        download_en = 1'b1;
        tick();
        exp_loaded = '0;
        n_tests++;
        if (done !== 1'b0 || loaded !== '0) begin
            n_fail++; $display("FAIL start_clear2: got done %b loaded %b expected 0/0", done, loaded);
        end
    endtask

    initial begin
        test_reset();
        test_mapped_byte();
        test_bank1();
        test_unmapped();
        test_coincident();
        test_reset_mid_strobe();
        test_random_bytes();
        test_stream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
